mul_dispatch: RTL and testbench
===============================

Name: mul_dispatch

Overview:
- Issue/writeback controller wrapped around the 4-cycle unpipelined 32-bit multiplier (mul32) in the execute stage.
- Upstream: the reservation station delivers RV32M MUL/MULH/MULHSU/MULHU ops, each with a ROB tag.
- The block buffers these ops, drives the multiplier's idle/in_en handshake and selects the hi or lo word of the product.
- It holds each result until the CDB arbiter grants it, and handles pipeline flush.

Parameters:
- DEPTH, 2, input FIFO entries; power of two, >= 2.
- ROB_W, 5, ROB tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  op offered by reservation station
- in_ready  out  1  FIFO can accept
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- in_rs1  in  32  operand a
- in_rs2  in  32  operand b
- in_tag  in  ROB_W  destination ROB index
- flush  in  1  misprediction; cancel everything
- mul_in_en  out  1  start multiplier
- mul_a  out  32  multiplier operand a
- mul_b  out  32  multiplier operand b
- mul_a_signed  out  1  multiplier sign control for a
- mul_b_signed  out  1  multiplier sign control for b
- mul_idle  in  1  multiplier idle
- mul_out_en  in  1  multiplier result valid (one-cycle pulse)
- mul_hi  in  32  product high word
- mul_lo  in  32  product low word
- cdb_valid  out  1  result pending on CDB
- cdb_tag  out  ROB_W  result tag
- cdb_data  out  32  result value
- cdb_grant  in  1  arbiter accepts result this cycle

Behaviour:
- Reset (async, rst=1): FIFO empty, state IDLE, discard=0.
  - in_ready=1, mul_in_en=0, cdb_valid=0, cdb_tag=0, cdb_data=0.
  - mul_a/mul_b/sign outputs are 0.
- Enqueue: the FIFO pushes on in_valid && in_ready.
  - in_ready = !full, computed from registered count only.
  - A pop in the same cycle does not free a slot for that cycle's push.
- Sign mapping:
  - MUL: a_signed=1, b_signed=1, result lo.
  - MULH: 1/1, result hi.
  - MULHSU: 1/0, result hi.
  - MULHU: 0/0, result hi.
- FSM states: IDLE, BUSY, HOLD, DRAIN.
  - IDLE: if FIFO nonempty && mul_idle && !flush:
    - assert mul_in_en combinationally with the head's operands and signs;
    - pop the head; latch its tag and a hi/lo select flag; go to BUSY.
  - BUSY: on mul_out_en:
    - register cdb_data = select ? mul_hi : mul_lo, and cdb_tag;
    - set cdb_valid; go to HOLD.
  - HOLD: cdb_valid stays 1 and data stays stable until cdb_valid && cdb_grant.
    - On grant: cdb_valid=0 next cycle; go to IDLE.
    - No issue occurs in the grant cycle. Minimum result-to-next-issue gap is 1 cycle.
  - DRAIN: wait for mul_out_en, drop the result, go to IDLE. mul32 cannot be aborted.
- Latency: push at cycle 0 → issue at cycle 1 at the earliest.
  - mul_out_en arrives 4 cycles after mul_in_en.
  - cdb_valid rises the cycle after mul_out_en.
- Flush (highest priority, synchronous):
  - empties the FIFO and drops that cycle's push;
  - IDLE → stays IDLE with no issue;
  - BUSY → DRAIN;
  - HOLD → cdb_valid=0 next cycle, IDLE (flush overrides a simultaneous grant);
  - DRAIN → stays DRAIN.
  - Flush coinciding with mul_out_en in BUSY: result dropped, next state IDLE.
- Only one op is outstanding at the multiplier.
  - mul_out_en seen in IDLE or HOLD is ignored (assertion in the bench).
- Async reset mid-operation returns to the reset state regardless of multiplier state.
  - The multiplier shares rst.

Optional Feature:
- MUL_ZERO_BYPASS_EN
  - Defined: in IDLE, if the head has rs1==0 or rs2==0, pop it without asserting mul_in_en.
    - The op goes directly to HOLD with cdb_data=0 and cdb_valid the next cycle.
    - It does not require mul_idle.
  - Undefined: every op goes through the multiplier.

Decomposition:
- Package mul_pkg:
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU);
  - state enum;
  - function op_signs(op) → {a_signed, b_signed, use_hi}.
- Sub-module sync_fifo (DEPTH, payload width), reusable elsewhere.
- The FSM stays in mul_dispatch.

Test Plan:
- MUL rs1=0xFFFFFFFF rs2=2 tag=3 → cdb_data=0xFFFFFFFE, tag 3, cdb_valid 6 cycles after push; grant in the same cycle.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Push 3 ops back-to-back with cdb_grant held low:
  - in_ready drops after 2 FIFO entries;
  - the result is held stable for 10 cycles;
  - after grants, all three tags appear in order.
- Flush 2 cycles after mul_in_en:
  - FIFO empties; the later mul_out_en produces no cdb_valid;
  - a new op pushed after flush completes with a correct result.
- Flush and cdb_grant in the same HOLD cycle → cdb_valid=0 next cycle, no duplicate broadcast.
- Async rst asserted in BUSY → all outputs at reset values immediately; in_ready=1 after release.
- With MUL_ZERO_BYPASS_EN: MUL 0×0x1234 → cdb_valid 2 cycles after push, mul_in_en never asserted.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the multiplier dispatch block: RV32M op encoding, FSM states
// and the op -> sign/word-select decode.
package mul_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic use_hi;
  } op_ctrl_t;

  // Only plain MUL returns the low word; all MULH variants return the high word.
  function automatic op_ctrl_t op_signs(input mul_op_e op);
    op_ctrl_t c;
    c.a_signed = 1'b0;
    c.b_signed = 1'b0;
    c.use_hi   = 1'b0;
    case (op)
      OP_MUL:    begin c.a_signed = 1'b1; c.b_signed = 1'b1; c.use_hi = 1'b0; end
      OP_MULH:   begin c.a_signed = 1'b1; c.b_signed = 1'b1; c.use_hi = 1'b1; end
      OP_MULHSU: begin c.a_signed = 1'b1; c.b_signed = 1'b0; c.use_hi = 1'b1; end
      OP_MULHU:  begin c.a_signed = 1'b0; c.b_signed = 1'b0; c.use_hi = 1'b1; end
      default:   begin c.a_signed = 1'b0; c.b_signed = 1'b0; c.use_hi = 1'b0; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with synchronous flush; DEPTH must be a power of two.
// Fullness comes from the registered count only, so a pop never frees a slot for the same cycle's push.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mul_dispatch.sv
// Issue/writeback controller around the 4-cycle unpipelined mul32: buffers RV32M ops,
// issues one at a time, holds the result for the CDB. Optional MUL_ZERO_BYPASS_EN skips zero operands.
module mul_dispatch
  import mul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ROB_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [ROB_W-1:0] in_tag,
  input  logic             flush,
  output logic             mul_in_en,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_a_signed,
  output logic             mul_b_signed,
  input  logic             mul_idle,
  input  logic             mul_out_en,
  input  logic [31:0]      mul_hi,
  input  logic [31:0]      mul_lo,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  input  logic             cdb_grant
);

  localparam int PW = 2 + 2 * XLEN + ROB_W;

  logic [PW-1:0]    push_data, head_data;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [1:0]       head_op;
  logic [31:0]      head_rs1, head_rs2;
  logic [ROB_W-1:0] head_tag;
  op_ctrl_t         head_ctrl;
  logic             issue;

  state_e           state_q, state_d;
  logic [ROB_W-1:0] tag_q, tag_d;
  logic             use_hi_q, use_hi_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]      cdb_data_q, cdb_data_d;

  assign push_data = {in_op, in_rs1, in_rs2, in_tag};
  assign {head_op, head_rs1, head_rs2, head_tag} = head_data;
  assign head_ctrl = op_signs(mul_op_e'(head_op));

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (in_valid && in_ready),
    .pop_i   (fifo_pop),
    .data_i  (push_data),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready = !fifo_full;

  // Operand/sign outputs are gated so the multiplier sees zeros whenever no op is issued.
  assign mul_in_en    = issue;
  assign mul_a        = issue ? head_rs1 : '0;
  assign mul_b        = issue ? head_rs2 : '0;
  assign mul_a_signed = issue && head_ctrl.a_signed;
  assign mul_b_signed = issue && head_ctrl.b_signed;

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    use_hi_d    = use_hi_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    issue       = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush && !fifo_empty) begin
`ifdef MUL_ZERO_BYPASS_EN
          if (head_rs1 == '0 || head_rs2 == '0) begin
            fifo_pop    = 1'b1;
            cdb_valid_d = 1'b1;
            cdb_tag_d   = head_tag;
            cdb_data_d  = '0;
            state_d     = ST_HOLD;
          end else
`endif
          if (mul_idle) begin
            issue    = 1'b1;
            fifo_pop = 1'b1;
            tag_d    = head_tag;
            use_hi_d = head_ctrl.use_hi;
            state_d  = ST_BUSY;
          end
        end
      end
      // A flush cannot abort mul32, so the in-flight result must be drained unless it lands now.
      ST_BUSY: begin
        if (flush) begin
          state_d = mul_out_en ? ST_IDLE : ST_DRAIN;
        end else if (mul_out_en) begin
          cdb_valid_d = 1'b1;
          cdb_tag_d   = tag_q;
          cdb_data_d  = use_hi_q ? mul_hi : mul_lo;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (flush || cdb_grant) begin
          cdb_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mul_out_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tag_q       <= '0;
      use_hi_q    <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      use_hi_q    <= use_hi_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

endmodule

// File: tb/tb_mul_dispatch.sv
// Self-checking bench for mul_dispatch with a behavioural 4-cycle mul32 model.
// Honours MUL_ZERO_BYPASS_EN for the zero-operand scenario.
module tb_mul_dispatch;

  localparam int DEPTH = 2;
  localparam int ROB_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_rs1, in_rs2;
  logic [ROB_W-1:0] in_tag;
  logic             flush;
  logic             mul_in_en;
  logic [31:0]      mul_a, mul_b;
  logic             mul_a_signed, mul_b_signed;
  logic             mul_idle, mul_out_en;
  logic [31:0]      mul_hi, mul_lo;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_grant;

  int compared   = 0;
  int mismatched = 0;
  int issueCount = 0;
  int protoErr   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  tag;
    logic        sa;
    logic        sb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  mul_dispatch #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_tag       (in_tag),
    .flush        (flush),
    .mul_in_en    (mul_in_en),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_a_signed (mul_a_signed),
    .mul_b_signed (mul_b_signed),
    .mul_idle     (mul_idle),
    .mul_out_en   (mul_out_en),
    .mul_hi       (mul_hi),
    .mul_lo       (mul_lo),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_grant    (cdb_grant)
  );

  always #5 clk = ~clk;

  // Behavioural mul32: result pulse 4 cycles after a start, not abortable, shares rst.
  logic [2:0]  mcnt;
  logic [63:0] prod;

  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb);
    logic signed [65:0] ea, eb, p;
    ea = $signed({{34{sa & a[31]}}, a});
    eb = $signed({{34{sb & b[31]}}, b});
    p  = ea * eb;
    return p[63:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 3'd0;
      prod <= 64'd0;
    end else if (mul_in_en) begin
      mcnt <= 3'd4;
      prod <= refProduct(mul_a, mul_b, mul_a_signed, mul_b_signed);
    end else if (mcnt != 3'd0) begin
      mcnt <= mcnt - 3'd1;
    end
  end

  assign mul_out_en = (mcnt == 3'd1);
  assign mul_idle   = (mcnt == 3'd0);
  assign mul_hi     = prod[63:32];
  assign mul_lo     = prod[31:0];

  always @(posedge clk) begin
    if (mul_in_en) begin
      issueCount++;
      if (!mul_idle) protoErr++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one op at a negedge, waits for its push edge, returns at the following negedge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [4:0] tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready before push", in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_tag   = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitValid(output int cyc);
    cyc = 1;
    while (!cdb_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic grantOnce();
    cdb_grant = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cdb_grant = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input string name);
    int cyc;
    applyStimulus(v.op, v.rs1, v.rs2, v.tag);
    checkOutput({name, " mul_in_en"}, mul_in_en, 1);
    checkOutput({name, " a_signed"}, mul_a_signed, v.sa);
    checkOutput({name, " b_signed"}, mul_b_signed, v.sb);
    checkOutput({name, " mul_a"}, mul_a, v.rs1);
    checkOutput({name, " mul_b"}, mul_b, v.rs2);
    waitValid(cyc);
    checkOutput({name, " latency"}, cyc, 6);
    checkOutput({name, " cdb_data"}, cdb_data, v.exp);
    checkOutput({name, " cdb_tag"}, cdb_tag, v.tag);
    grantOnce();
    checkOutput({name, " valid after grant"}, cdb_valid, 0);
  endtask

  initial begin
    int          cyc, issues0, seen;
    logic [31:0] bExp[3];
    logic [4:0]  bTag[3];
    vec_t        v;

    vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 5'd3,  1'b1, 1'b1, 32'hFFFFFFFE};
    vecs[1] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  1'b0, 1'b0, 32'hFFFFFFFE};
    vecs[2] = '{2'b01, 32'h80000000, 32'h80000000, 5'd6,  1'b1, 1'b1, 32'h40000000};
    vecs[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  1'b1, 1'b0, 32'hFFFFFFFF};
    vecs[4] = '{2'b00, 32'h00000007, 32'h00000006, 5'd13, 1'b1, 1'b1, 32'h0000002A};
    vecs[5] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 1'b1, 1'b1, 32'h00000000};
    vecs[6] = '{2'b00, 32'h12345678, 32'h00000010, 5'd30, 1'b1, 1'b1, 32'h23456780};
    vecs[7] = '{2'b11, 32'h80000000, 32'h00000004, 5'd31, 1'b0, 1'b0, 32'h00000002};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_rs1    = '0;
    in_rs2    = '0;
    in_tag    = '0;
    flush     = 1'b0;
    cdb_grant = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset mul_in_en", mul_in_en, 0);
    checkOutput("reset cdb_valid", cdb_valid, 0);
    checkOutput("reset cdb_tag", cdb_tag, 0);
    checkOutput("reset cdb_data", cdb_data, 0);
    checkOutput("reset mul_a", mul_a, 0);
    checkOutput("reset mul_b", mul_b, 0);
    checkOutput("reset signs", {mul_a_signed, mul_b_signed}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Three back-to-back pushes with the grant held low.
    bExp = '{32'h0000000F, 32'h00000001, 32'hFFFFFFFF};
    bTag = '{5'd10, 5'd11, 5'd12};
    in_valid = 1'b1;
    in_op = 2'b00; in_rs1 = 32'd3;          in_rs2 = 32'd5; in_tag = bTag[0];
    @(posedge clk); @(negedge clk);
    in_op = 2'b11; in_rs1 = 32'hFFFFFFFF;   in_rs2 = 32'd2; in_tag = bTag[1];
    @(posedge clk); @(negedge clk);
    in_op = 2'b01; in_rs1 = 32'hFFFFFFFE;   in_rs2 = 32'd3; in_tag = bTag[2];
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checkOutput("b2b in_ready full", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      waitValid(cyc);
      checkOutput($sformatf("b2b%0d valid", i), cdb_valid, 1);
      checkOutput($sformatf("b2b%0d tag", i), cdb_tag, bTag[i]);
      checkOutput($sformatf("b2b%0d data", i), cdb_data, bExp[i]);
      if (i == 0) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          checkOutput($sformatf("hold%0d valid", k), cdb_valid, 1);
          checkOutput($sformatf("hold%0d data", k), cdb_data, bExp[0]);
          checkOutput($sformatf("hold%0d tag", k), cdb_tag, bTag[0]);
        end
      end
      grantOnce();
    end

    // Flush two cycles after issue, with a second op still queued.
    applyStimulus(2'b00, 32'd7, 32'd9, 5'd1);
    checkOutput("flush issue", mul_in_en, 1);
    in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd5; in_rs2 = 32'd5; in_tag = 5'd2;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    issues0 = issueCount;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    checkOutput("flush in_ready", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (cdb_valid) seen++;
      @(negedge clk);
    end
    checkOutput("flush no cdb_valid", seen, 0);
    checkOutput("flush no reissue", issueCount - issues0, 0);
    v = '{2'b11, 32'h00010000, 32'h00010000, 5'd7, 1'b0, 1'b0, 32'h00000001};
    runVector(v, "post-flush");

    // Flush and grant together in HOLD.
    applyStimulus(2'b00, 32'd6, 32'd7, 5'd4);
    waitValid(cyc);
    checkOutput("fg data", cdb_data, 32'd42);
    issues0 = issueCount;
    flush = 1'b1;
    cdb_grant = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    cdb_grant = 1'b0;
    checkOutput("fg valid low", cdb_valid, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cdb_valid) seen++;
    end
    checkOutput("fg no duplicate", seen, 0);
    checkOutput("fg no issue", issueCount - issues0, 0);

    // Async reset while the multiplier is busy, with a second op queued.
    applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
    in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd2; in_rs2 = 32'd3; in_tag = 5'd22;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("arst in_ready", in_ready, 1);
    checkOutput("arst mul_in_en", mul_in_en, 0);
    checkOutput("arst cdb_valid", cdb_valid, 0);
    checkOutput("arst cdb_tag", cdb_tag, 0);
    checkOutput("arst cdb_data", cdb_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("arst in_ready after release", in_ready, 1);
    issues0 = issueCount;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (cdb_valid) seen++;
      @(negedge clk);
    end
    checkOutput("arst queue cleared", issueCount - issues0, 0);
    checkOutput("arst no result", seen, 0);

    // Zero operand.
`ifdef MUL_ZERO_BYPASS_EN
    issues0 = issueCount;
    applyStimulus(2'b00, 32'h00000000, 32'h00001234, 5'd9);
    waitValid(cyc);
    checkOutput("bypass latency", cyc, 2);
    checkOutput("bypass data", cdb_data, 0);
    checkOutput("bypass tag", cdb_tag, 5'd9);
    checkOutput("bypass no mul_in_en", issueCount - issues0, 0);
    grantOnce();
    checkOutput("bypass valid after grant", cdb_valid, 0);
`else
    v = '{2'b00, 32'h00000000, 32'h00001234, 5'd9, 1'b1, 1'b1, 32'h00000000};
    runVector(v, "zero-op");
`endif

    checkOutput("mul_in_en while multiplier busy", protoErr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
